// File: rtl/gray_converter.sv
// gray_converter: reads RGB pixels from memory in raster order and streams 8-bit luminance over valid/ready.
// Optional macro GRY_THRESH_EN adds input Gry_THR and binarises each pixel against it.
module gray_converter #(
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 342,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned BUS_WIDTH  = 32,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR = {BUS_WIDTH{1'b0}},
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  Gry_CLK,
    input  logic                  Gry_RSTn,
    input  logic                  Gry_STRT,
    output logic                  Gry_REN,
    output logic [BUS_WIDTH-1:0]  Gry_RADDR,
    input  logic [DATA_WIDTH-1:0] Gry_DIn,
    output logic [7:0]            Gry_DOut,
    output logic                  Gry_VLD,
    input  logic                  Gry_RDY,
    output logic                  Gry_LAST,
    output logic                  Gry_BSY,
    output logic                  Gry_DNE
`ifdef GRY_THRESH_EN
    ,
    input  logic [7:0]            Gry_THR
`endif
);
    localparam int unsigned N      = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned CNT_W  = $clog2(N + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1'b1);
    localparam logic [FCNT_W:0]   CREDITS  = (FCNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_t;

    function automatic logic [7:0] lum_f(input logic [23:0] rgb);
        logic [15:0] acc;
        acc = 16'd77 * {8'd0, rgb[23:16]} + 16'd150 * {8'd0, rgb[15:8]}
            + 16'd29 * {8'd0, rgb[7:0]} + 16'd128;
        return acc[15:8];
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc_f(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? {PTR_W{1'b0}} : p + PTR_ONE;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_rd_cnt, r_out_cnt;
    logic                r_ren, r_dvld, r_bsy, r_dne;
    logic [BUS_WIDTH-1:0] r_raddr;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [FCNT_W-1:0]   r_fcnt;
    logic                w_issue, w_clr, w_vld, w_pop, w_push, w_credit;
    logic [FCNT_W:0]     w_used;
    logic [7:0]          w_y, w_pix;

    // Slots already promised: FIFO contents plus reads issued now and data arriving now.
    assign w_used   = (FCNT_W + 1)'(r_fcnt) + (FCNT_W + 1)'(r_ren) + (FCNT_W + 1)'(r_dvld);
    assign w_credit = (w_used < CREDITS);
    assign w_vld    = (r_fcnt != {FCNT_W{1'b0}});
    assign w_pop    = w_vld && Gry_RDY;
    assign w_push   = r_dvld;
    assign w_y      = lum_f(Gry_DIn[23:0]);
`ifdef GRY_THRESH_EN
    assign w_pix    = (w_y >= Gry_THR) ? 8'hFF : 8'h00;
`else
    assign w_pix    = w_y;
`endif

    // Next-state and read-issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Gry_STRT) begin
                    w_state_nxt = ST_READ;
                    w_clr       = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (w_credit) begin
                    w_issue     = 1'b1;
                    w_state_nxt = (r_rd_cnt == LAST_IDX) ? ST_DRAIN : ST_READ;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (w_pop && (r_out_cnt == LAST_IDX)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered control outputs.
    always_ff @(posedge Gry_CLK or negedge Gry_RSTn) begin
        if (!Gry_RSTn) begin
            r_state   <= ST_IDLE;
            r_rd_cnt  <= {CNT_W{1'b0}};
            r_out_cnt <= {CNT_W{1'b0}};
            r_ren     <= 1'b0;
            r_dvld    <= 1'b0;
            r_raddr   <= BASE_ADDR;
            r_bsy     <= 1'b0;
            r_dne     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ren     <= w_issue;
            r_dvld    <= r_ren;
            r_bsy     <= (w_state_nxt != ST_IDLE);
            r_dne     <= (w_state_nxt == ST_DONE);
            if (w_issue) begin
                r_raddr <= BASE_ADDR + BUS_WIDTH'(r_rd_cnt);
            end
            if (w_clr) begin
                r_rd_cnt  <= {CNT_W{1'b0}};
                r_out_cnt <= {CNT_W{1'b0}};
            end else begin
                if (w_issue) r_rd_cnt  <= r_rd_cnt + CNT_ONE;
                if (w_pop)   r_out_cnt <= r_out_cnt + CNT_ONE;
            end
        end
    end

    // Output FIFO: converted pixel pushed the cycle its memory data arrives.
    always_ff @(posedge Gry_CLK or negedge Gry_RSTn) begin
        if (!Gry_RSTn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
            r_wptr <= {PTR_W{1'b0}};
            r_rptr <= {PTR_W{1'b0}};
            r_fcnt <= {FCNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_pix;
                r_wptr        <= ptr_inc_f(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc_f(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + FCNT_ONE;
                2'b01:   r_fcnt <= r_fcnt - FCNT_ONE;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    assign Gry_REN   = r_ren;
    assign Gry_RADDR = r_raddr;
    assign Gry_VLD   = w_vld;
    assign Gry_DOut  = w_vld ? r_mem[r_rptr] : 8'h00;
    assign Gry_LAST  = w_vld && (r_out_cnt == LAST_IDX);
    assign Gry_BSY   = r_bsy;
    assign Gry_DNE   = r_dne;

    gray_converter_chk #(.FIFO_DEPTH(FIFO_DEPTH), .FCNT_W(FCNT_W)) u_chk (
        .clk   (Gry_CLK),
        .rst_n (Gry_RSTn),
        .push  (w_push),
        .fcnt  (r_fcnt)
    );
endmodule

// Credit issue must make a push into a full FIFO impossible.
module gray_converter_chk #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FCNT_W     = 3
) (
    input logic              clk,
    input logic              rst_n,
    input logic              push,
    input logic [FCNT_W-1:0] fcnt
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (fcnt == FCNT_W'(FIFO_DEPTH))));
endmodule

// File: tb/tb_gray_converter.sv
// Randomised self-checking bench for gray_converter: memory model, luminance reference queue, stream monitor.
`timescale 1ns/1ps
module tb_gray_converter;
    localparam int unsigned W = 6, H = 4, N = W * H, DEPTH = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int THR = 100;

    logic        clk = 1'b0, rst_n = 1'b0, strt = 1'b0, rdy = 1'b0;
    logic        ren, vld, last, bsy, dne;
    logic [31:0] raddr;
    logic [23:0] din = 24'h0;
    logic [7:0]  dout;
`ifdef GRY_THRESH_EN
    logic [7:0]  thr = 8'(THR);
`endif

    int checks = 0, errors = 0;
    logic [23:0] mem [N];
    int exp_q[$];
    int exp_rd = 0, idx = 0, dne_cnt = 0, rdy_mode = 0, d0, dne_cyc;
    logic prev_vld = 1'b0, prev_rdy = 1'b0;
    int prev_dout = 0;

    always #5 clk = ~clk;

    gray_converter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(24), .BUS_WIDTH(32),
                     .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .Gry_CLK(clk), .Gry_RSTn(rst_n), .Gry_STRT(strt), .Gry_REN(ren), .Gry_RADDR(raddr),
        .Gry_DIn(din), .Gry_DOut(dout), .Gry_VLD(vld), .Gry_RDY(rdy), .Gry_LAST(last),
        .Gry_BSY(bsy), .Gry_DNE(dne)
`ifdef GRY_THRESH_EN
        , .Gry_THR(thr)
`endif
    );

    function automatic int ref_pix(input logic [23:0] rgb);
        int y;
        y = (77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]) + 128) / 256;
`ifdef GRY_THRESH_EN
        y = (y >= THR) ? 255 : 0;
`endif
        return y;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        idx = 0;
        exp_rd = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(ref_pix(mem[i]));
    endtask

    task automatic pulse_start();
        strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
    endtask

    task automatic wait_dne(input int base, input int max_cyc);
        for (int i = 0; i < max_cyc && dne_cnt <= base; i++) @(negedge clk);
        chk("dne_seen", int'(dne_cnt > base), 1);
    endtask

    // Single-cycle memory: data for a read in cycle k is presented during cycle k+1.
    always @(posedge clk) begin
        if (ren && raddr >= BASE && raddr < BASE + N) din <= mem[raddr - BASE];
        else din <= 24'h0;
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = stalled.
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 3) != 0);
            default: rdy = 1'b0;
        endcase
    end

    // Stream monitor: addresses, data order, LAST, hold-while-stalled, DNE count.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                chk("hold_vld", int'(vld), 1);
                chk("hold_dout", int'(dout), prev_dout);
            end
            if (ren) begin
                chk("raddr", int'(raddr), int'(BASE) + exp_rd);
                exp_rd++;
            end
            if (vld && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_xfer", 1, 0);
                end else begin
                    chk("dout", int'(dout), exp_q.pop_front());
                    chk("last", int'(last), int'(idx == N - 1));
                    idx++;
                end
            end
            if (dne) dne_cnt++;
            prev_vld  = vld;
            prev_rdy  = rdy;
            prev_dout = int'(dout);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rdy_mode = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_ren", int'(ren), 0);
        chk("rst_raddr", int'(raddr), int'(BASE));
        chk("rst_dout", int'(dout), 0);
        chk("rst_vld", int'(vld), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_bsy", int'(bsy), 0);
        chk("rst_dne", int'(dne), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame A: known pixels, always ready, exact cycle timing.
        mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h0000FF; mem[3] = 24'h808080;
        for (int i = 4; i < N; i++) mem[i] = 24'($urandom);
        start_frame();
        pulse_start();
        dne_cyc = -1;
        for (int c = 0; c < N + 20 && dne_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 0) begin chk("c0_ren", int'(ren), 0); chk("c0_bsy", int'(bsy), 1); end
            if (c == 1) begin chk("c1_ren", int'(ren), 1); chk("c1_raddr", int'(raddr), int'(BASE)); end
            if (c == 2) chk("c2_vld", int'(vld), 0);
            if (c == 3) begin chk("c3_vld", int'(vld), 1); chk("c3_dout", int'(dout), ref_pix(24'hFF0000)); end
            if (c == 6) chk("c6_dout", int'(dout), ref_pix(24'h808080));
            if (dne) dne_cyc = c;
        end
        chk("a_dne_cycle", dne_cyc, N + 3);
        @(negedge clk);
        chk("a_idle_bsy", int'(bsy), 0);
        chk("a_count", idx, N);
        chk("a_dne_cnt", dne_cnt, 1);

        // Frame B: random ready, ignored restart, 20-cycle stall.
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
        start_frame();
        d0 = dne_cnt;
        rdy_mode = 1;
        pulse_start();
        repeat (3) @(posedge clk); #1;
        pulse_start();
        for (int i = 0; i < 200 && idx < 6; i++) @(negedge clk);
        chk("b_reach_mid", int'(idx >= 6), 1);
        rdy_mode = 2;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_ren", int'(ren), 0);
        chk("bp_vld", int'(vld), 1);
        chk("bp_fifo_full", exp_rd - idx, DEPTH);
        rdy_mode = 1;
        wait_dne(d0, 400);
        repeat (10) @(negedge clk);
        chk("b_count", idx, N);
        chk("b_reads", exp_rd, N);
        chk("b_one_dne", dne_cnt - d0, 1);
        chk("b_idle_bsy", int'(bsy), 0);

        // Frame C: reset while a read is in flight.
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
        start_frame();
        pulse_start();
        repeat (3) @(posedge clk); #1;
        chk("c_ren_active", int'(ren), 1);
        rst_n = 1'b0;
        #1;
        chk("c_rst_ren", int'(ren), 0);
        chk("c_rst_raddr", int'(raddr), int'(BASE));
        chk("c_rst_vld", int'(vld), 0);
        chk("c_rst_dout", int'(dout), 0);
        chk("c_rst_last", int'(last), 0);
        chk("c_rst_bsy", int'(bsy), 0);
        chk("c_rst_dne", int'(dne), 0);
        repeat (2) @(posedge clk);

        // Frame D: clean restart after reset.
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
        start_frame();
        d0 = dne_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        wait_dne(d0, 400);
        repeat (3) @(negedge clk);
        chk("d_count", idx, N);
        chk("d_reads", exp_rd, N);
        chk("d_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
